// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder backed by NUM_REGS 32-bit registers with byte strobes,
// SLVERR on out-of-range addresses, and a flat export of all register contents.
module axi4_lite_slave_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [32*NUM_REGS-1:0]   regs_out
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RESP} wr_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  wr_state_t        r_wr_state;
  logic             r_oor;
  logic [31:0]      r_regs [NUM_REGS];
  logic             r_aw_held;
  logic             r_aw_ok;
  logic [IDX_W-1:0] r_aw_idx;
  logic             r_w_held;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_rvalid;
  logic [1:0]       r_rresp;
  logic [31:0]      r_rdata;

  logic [IDX_W-1:0] w_aw_idx;
  logic             w_aw_ok;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_ar_ok;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_unused_ok;

  // Index sits just above the byte offset; anything set above it is out of range.
  assign w_aw_idx = awaddr[2 +: IDX_W];
  assign w_aw_ok  = (awaddr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign w_ar_idx = araddr[2 +: IDX_W];
  assign w_ar_ok  = (araddr[ADDR_WIDTH-1:IDX_W+2] == '0);

  assign awready = r_oor & ~r_aw_held & ~r_bvalid;
  assign wready  = r_oor & ~r_w_held  & ~r_bvalid;
  assign arready = r_oor & ~r_rvalid;

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid  & wready;
  assign w_ar_hs = arvalid & arready;

  assign bvalid = r_bvalid;
  assign bresp  = r_bresp;
  assign rvalid = r_rvalid;
  assign rresp  = r_rresp;
  assign rdata  = r_rdata;

  assign w_unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = r_regs[g];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_oor <= 1'b0;
    end else begin
      r_oor <= 1'b1;
    end
  end

  // Write FSM: collect AW and W in any order, commit one edge after the pair completes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= S_IDLE;
      r_aw_held  <= 1'b0;
      r_aw_ok    <= 1'b0;
      r_aw_idx   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_wr_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_ok   <= w_aw_ok;
            r_aw_idx  <= w_aw_idx;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
          end
          if ((r_aw_held | w_aw_hs) & (r_w_held | w_w_hs)) r_wr_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_aw_ok) r_regs[r_aw_idx] <= apply_strb(r_regs[r_aw_idx], r_wdata, r_wstrb);
          r_bvalid   <= 1'b1;
          r_bresp    <= r_aw_ok ? RESP_OKAY : RESP_SLVERR;
          r_aw_held  <= 1'b0;
          r_w_held   <= 1'b0;
          r_wr_state <= S_RESP;
        end
        S_RESP: begin
          if (bready) begin
            r_bvalid   <= 1'b0;
            r_wr_state <= S_IDLE;
          end
        end
        default: r_wr_state <= S_IDLE;
      endcase
    end
  end

  // Read path: single-cycle lookup, held until the R handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      r_rdata  <= w_ar_ok ? r_regs[w_ar_idx] : 32'h0;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Scoreboard bench for axi4_lite_slave_regfile: expected B/R responses are queued
// when requests are issued and compared when the DUT completes each handshake.
module tb_axi4_lite_slave_regfile;

  localparam int ADDR_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int IDX_W      = 4;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic [ADDR_WIDTH-1:0]  awaddr = '0;
  logic [2:0]             awprot = '0;
  logic                   awvalid = 1'b0;
  logic                   awready;
  logic [31:0]            wdata = '0;
  logic [3:0]             wstrb = '0;
  logic                   wvalid = 1'b0;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready = 1'b1;
  logic [ADDR_WIDTH-1:0]  araddr = '0;
  logic [2:0]             arprot = '0;
  logic                   arvalid = 1'b0;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready = 1'b1;
  logic [32*NUM_REGS-1:0] regs_out;

  axi4_lite_slave_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mdl [NUM_REGS];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 32'(bresp), 32'hFFFF_FFFF);
      else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
    end
    if (aresetn && rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", rdata, 32'hFFFF_FFFF);
      else begin
        logic [33:0] e;
        e = exp_r.pop_front();
        chk("rdata", rdata, e[33:2]);
        chk("rresp", 32'(rresp), 32'(e[1:0]));
      end
    end
  end

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >> (2 + IDX_W)) == 0;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    awaddr = a; awvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (awready) break;
    end
    if (!awready) chk("aw_timeout", 32'(awready), 32'h1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (wready) break;
    end
    if (!wready) chk("w_timeout", 32'(wready), 32'h1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge aclk);
      if (arready) break;
    end
    if (!arready) chk("ar_timeout", 32'(arready), 32'h1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ok;
    int idx;
    ok = addr_ok(a);
    idx = int'(a[2 +: IDX_W]);
    exp_b.push_back(ok ? 2'b00 : 2'b10);
    if (ok) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    expect_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic expect_read(input logic [31:0] a);
    if (addr_ok(a)) exp_r.push_back({mdl[a[2 +: IDX_W]], 2'b00});
    else            exp_r.push_back({32'h0, 2'b10});
  endtask

  task automatic wait_b_done();
    for (int n = 0; n < 50 && exp_b.size() != 0; n++) @(posedge aclk);
    if (exp_b.size() != 0) chk("b_timeout", exp_b.size(), 0);
    tick();
  endtask

  task automatic wait_r_done();
    for (int n = 0; n < 50 && exp_r.size() != 0; n++) @(posedge aclk);
    if (exp_r.size() != 0) chk("r_timeout", exp_r.size(), 0);
    tick();
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("%s_r%0d", tag, i), regs_out[32*i +: 32], mdl[i]);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk_regs("rst");
    aresetn = 1'b1;
    chk("rel_awready_pre", 32'(awready), 0);
    tick();
    chk("rel_awready", 32'(awready), 1);
    chk("rel_arready", 32'(arready), 1);

    // 1: AW+W together, B one cycle after the handshake, then read back
    do_write(32'h4, 32'hDEADBEEF, 4'hF);
    chk("t1_bvalid_n", 32'(bvalid), 0);
    tick();
    chk("t1_bvalid_n1", 32'(bvalid), 1);
    wait_b_done();
    chk("t1_reg1", regs_out[63:32], 32'hDEADBEEF);
    expect_read(32'h4);
    send_ar(32'h4);
    chk("t1_rvalid", 32'(rvalid), 1);
    wait_r_done();

    // 2: W leads AW by three cycles, partial strobes
    expect_write(32'h8, 32'h11223344, 4'h5);
    send_w(32'h11223344, 4'h5);
    chk("t2_wready_held", 32'(wready), 0);
    tick();
    tick();
    chk("t2_wready_still", 32'(wready), 0);
    chk("t2_no_bvalid", 32'(bvalid), 0);
    send_aw(32'h8);
    wait_b_done();
    chk("t2_reg2", regs_out[32*2 +: 32], 32'h00220044);

    // 3: out-of-range write and read
    do_write(32'h40, 32'hFFFFFFFF, 4'hF);
    wait_b_done();
    expect_read(32'h40);
    send_ar(32'h40);
    wait_r_done();
    chk_regs("t3");

    // 4: B back-pressure, pending AW held off
    bready = 1'b0;
    do_write(32'h10, 32'hCAFEF00D, 4'hF);
    tick();
    awaddr = 32'h14; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid", 32'(bvalid), 1);
      chk("t4_bresp", 32'(bresp), 0);
      chk("t4_awready", 32'(awready), 0);
      chk("t4_wready", 32'(wready), 0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("t4_bvalid_fall", 32'(bvalid), 0);
    chk("t4_awready_back", 32'(awready), 1);
    tick();
    chk("t4_aw_taken", 32'(awready), 0);
    awvalid = 1'b0;
    expect_write(32'h14, 32'h0BADBEEF, 4'h3);
    send_w(32'h0BADBEEF, 4'h3);
    wait_b_done();
    chk("t4_reg4", regs_out[32*4 +: 32], 32'hCAFEF00D);
    chk("t4_reg5", regs_out[32*5 +: 32], 32'h0000BEEF);

    // 5: read held by rready=0 while a write lands on the same register
    rready = 1'b0;
    expect_read(32'hC);
    send_ar(32'hC);
    chk("t5_rvalid", 32'(rvalid), 1);
    do_write(32'hC, 32'h55, 4'hF);
    wait_b_done();
    chk("t5_reg3", regs_out[32*3 +: 32], 32'h55);
    for (int i = 0; i < 2; i++) begin
      chk("t5_rvalid_hold", 32'(rvalid), 1);
      chk("t5_rdata_hold", rdata, 32'h0);
      chk("t5_arready", 32'(arready), 0);
      tick();
    end
    rready = 1'b1;
    wait_r_done();
    expect_read(32'hC);
    send_ar(32'hC);
    wait_r_done();
    chk_regs("t5");

    // 6: reset with AW captured and W outstanding
    send_aw(32'h18);
    chk("t6_aw_held", 32'(awready), 0);
    aresetn = 1'b0;
    #2;
    chk("t6_rst_bvalid", 32'(bvalid), 0);
    chk("t6_rst_awready", 32'(awready), 0);
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
    chk_regs("t6_rst");
    tick();
    aresetn = 1'b1;
    chk("t6_awready_pre", 32'(awready), 0);
    tick();
    chk("t6_awready_first", 32'(awready), 1);
    send_w(32'hFFFFFFFF, 4'hF);
    repeat (3) tick();
    chk("t6_no_bvalid", 32'(bvalid), 0);
    chk_regs("t6");
    chk("end_b_queue", exp_b.size(), 0);
    chk("end_r_queue", exp_r.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
